// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU operation codes and the ID/EX record
// layout for the MIPS decode stage.
package mips_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [4:0] REG_RA = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOR = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic [4:0] write_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       link;
    alu_op_e    alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc_next;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    ctrl_t       ctrl;
  } id_ex_t;

  function automatic logic [31:0] ext_imm16(input logic [15:0] imm, input logic zero_ext);
    return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of every signal the decode stage exchanges with IF, EX/MEM and WB.
// The slave side is the decode stage; the master side is its surroundings.
interface id_stage_if;

  logic [31:0] if_id_pc_next;
  logic [31:0] if_id_instruction;

  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;

  logic        ex_mem_reg_write;
  logic        ex_mem_mem_read;
  logic [4:0]  ex_mem_write_reg;
  logic [31:0] ex_mem_alu_result;

  logic        stall;
  logic        flush_if;
  logic        jump_taken;
  logic [31:0] pc_jump;
  logic        branch_eq_taken;
  logic        branch_neq_taken;
  logic [31:0] pc_branch;

  logic [31:0] id_ex_pc_next;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_write_reg;
  logic        id_ex_reg_write;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_mem_to_reg;
  logic        id_ex_alu_src;
  logic        id_ex_link;
  logic [2:0]  id_ex_alu_op;

  modport slave (
    input  if_id_pc_next, if_id_instruction,
    input  wb_reg_write, wb_write_reg, wb_write_data,
    input  ex_mem_reg_write, ex_mem_mem_read, ex_mem_write_reg, ex_mem_alu_result,
    output stall, flush_if, jump_taken, pc_jump,
    output branch_eq_taken, branch_neq_taken, pc_branch,
    output id_ex_pc_next, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    output id_ex_rs, id_ex_rt, id_ex_write_reg,
    output id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
    output id_ex_alu_src, id_ex_link, id_ex_alu_op
  );

  modport master (
    output if_id_pc_next, if_id_instruction,
    output wb_reg_write, wb_write_reg, wb_write_data,
    output ex_mem_reg_write, ex_mem_mem_read, ex_mem_write_reg, ex_mem_alu_result,
    input  stall, flush_if, jump_taken, pc_jump,
    input  branch_eq_taken, branch_neq_taken, pc_branch,
    input  id_ex_pc_next, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    input  id_ex_rs, id_ex_rt, id_ex_write_reg,
    input  id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
    input  id_ex_alu_src, id_ex_link, id_ex_alu_op
  );

endinterface

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports and one write port.
// r0 reads zero; a read of the register being written returns the new data.
module reg_file
  import mips_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_wa,
  input  logic [XLEN-1:0]       i_wd,
  input  logic [REG_ADDR_W-1:0] i_ra1,
  input  logic [REG_ADDR_W-1:0] i_ra2,
  output logic [XLEN-1:0]       o_rd1,
  output logic [XLEN-1:0]       o_rd2
);

  logic [XLEN-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    if (addr == '0)                 return '0;
    else if (i_we && (i_wa == addr)) return i_wd;
    else                            return r_mem[addr];
  endfunction

  always_comb begin
    o_rd1 = read_port(i_ra1);
    o_rd2 = read_port(i_ra2);
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction decode, register read, ID-resolved branches and
// jumps, hazard detection and the ID/EX pipeline register.
module id_stage (
  input  logic      clk,
  input  logic      rst,
  id_stage_if.slave bus
);
  import mips_pkg::*;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm16;

  assign w_opcode = bus.if_id_instruction[31:26];
  assign w_rs     = bus.if_id_instruction[25:21];
  assign w_rt     = bus.if_id_instruction[20:16];
  assign w_rd     = bus.if_id_instruction[15:11];
  assign w_imm16  = bus.if_id_instruction[15:0];
  assign w_funct  = bus.if_id_instruction[5:0];

  ctrl_t w_ctrl;
  logic  w_is_beq;
  logic  w_is_bne;
  logic  w_is_jump;
  logic  w_rt_src;
  logic  w_zero_ext;

  always_comb begin
    w_ctrl     = '0;
    w_is_beq   = 1'b0;
    w_is_bne   = 1'b0;
    w_is_jump  = 1'b0;
    w_rt_src   = 1'b0;
    w_zero_ext = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_rt_src         = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.write_reg = w_rd;
        case (w_funct)
          FN_ADD:  w_ctrl.alu_op = ALU_ADD;
          FN_SUB:  w_ctrl.alu_op = ALU_SUB;
          FN_AND:  w_ctrl.alu_op = ALU_AND;
          FN_OR:   w_ctrl.alu_op = ALU_OR;
          FN_SLT:  w_ctrl.alu_op = ALU_SLT;
          FN_NOR:  w_ctrl.alu_op = ALU_NOR;
          default: w_ctrl = '0;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.write_reg = w_rt;
        case (w_opcode)
          OP_SLTI: w_ctrl.alu_op = ALU_SLT;
          OP_ANDI: w_ctrl.alu_op = ALU_AND;
          OP_ORI:  w_ctrl.alu_op = ALU_OR;
          default: w_ctrl.alu_op = ALU_ADD;
        endcase
        w_zero_ext = (w_opcode == OP_ANDI) || (w_opcode == OP_ORI);
      end
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.write_reg  = w_rt;
      end
      OP_SW: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_rt_src         = 1'b1;
      end
      OP_BEQ: begin
        w_is_beq      = 1'b1;
        w_rt_src      = 1'b1;
        w_ctrl.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        w_is_bne      = 1'b1;
        w_rt_src      = 1'b1;
        w_ctrl.alu_op = ALU_SUB;
      end
      OP_J: w_is_jump = 1'b1;
      OP_JAL: begin
        w_is_jump        = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.link      = 1'b1;
        w_ctrl.write_reg = REG_RA;
      end
      default: ;
    endcase
  end

  logic [31:0] w_rf_rs;
  logic [31:0] w_rf_rt;

  reg_file u_reg_file (
    .i_clk (clk),
    .i_rst (rst),
    .i_we  (bus.wb_reg_write),
    .i_wa  (bus.wb_write_reg),
    .i_wd  (bus.wb_write_data),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rf_rs),
    .o_rd2 (w_rf_rt)
  );

  // Branch operands may come from an ALU result sitting in EX/MEM; loads there are not ready.
  logic        w_fwd_rs;
  logic        w_fwd_rt;
  logic [31:0] w_br_a;
  logic [31:0] w_br_b;

  assign w_fwd_rs = bus.ex_mem_reg_write && !bus.ex_mem_mem_read &&
                    (bus.ex_mem_write_reg != 5'd0) && (bus.ex_mem_write_reg == w_rs);
  assign w_fwd_rt = bus.ex_mem_reg_write && !bus.ex_mem_mem_read &&
                    (bus.ex_mem_write_reg != 5'd0) && (bus.ex_mem_write_reg == w_rt);
  assign w_br_a   = w_fwd_rs ? bus.ex_mem_alu_result : w_rf_rs;
  assign w_br_b   = w_fwd_rt ? bus.ex_mem_alu_result : w_rf_rt;

  id_ex_t r_id_ex;
  id_ex_t w_id_ex_d;
  logic   w_is_branch;
  logic   w_lu_hazard;
  logic   w_br_alu_hazard;
  logic   w_br_load_hazard;
  logic   w_stall;

  assign w_is_branch = w_is_beq || w_is_bne;

  assign w_lu_hazard = r_id_ex.ctrl.mem_read && (r_id_ex.rt != 5'd0) &&
                       ((r_id_ex.rt == w_rs) || (w_rt_src && (r_id_ex.rt == w_rt)));

  assign w_br_alu_hazard = w_is_branch && r_id_ex.ctrl.reg_write &&
                           (r_id_ex.ctrl.write_reg != 5'd0) &&
                           ((r_id_ex.ctrl.write_reg == w_rs) || (r_id_ex.ctrl.write_reg == w_rt));

  assign w_br_load_hazard = w_is_branch && bus.ex_mem_mem_read &&
                            (bus.ex_mem_write_reg != 5'd0) &&
                            ((bus.ex_mem_write_reg == w_rs) || (bus.ex_mem_write_reg == w_rt));

  assign w_stall = w_lu_hazard || w_br_alu_hazard || w_br_load_hazard;

  assign bus.stall            = w_stall;
  assign bus.branch_eq_taken  = w_is_beq && (w_br_a == w_br_b) && !w_stall;
  assign bus.branch_neq_taken = w_is_bne && (w_br_a != w_br_b) && !w_stall;
  assign bus.jump_taken       = w_is_jump && !w_stall;
  assign bus.flush_if         = bus.branch_eq_taken || bus.branch_neq_taken || bus.jump_taken;
  assign bus.pc_branch        = bus.if_id_pc_next + {{14{w_imm16[15]}}, w_imm16, 2'b00};
  assign bus.pc_jump          = {bus.if_id_pc_next[31:28], bus.if_id_instruction[25:0], 2'b00};

  always_comb begin
    w_id_ex_d         = '0;
    w_id_ex_d.pc_next = bus.if_id_pc_next;
    w_id_ex_d.rs_data = w_rf_rs;
    w_id_ex_d.rt_data = w_rf_rt;
    w_id_ex_d.imm     = ext_imm16(w_imm16, w_zero_ext);
    w_id_ex_d.rs      = w_rs;
    w_id_ex_d.rt      = w_rt;
    w_id_ex_d.ctrl    = w_ctrl;
  end

  // ID/EX boundary: a stall inserts an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_id_ex <= '0;
    else if (w_stall) r_id_ex <= '0;
    else              r_id_ex <= w_id_ex_d;
  end

  assign bus.id_ex_pc_next    = r_id_ex.pc_next;
  assign bus.id_ex_rs_data    = r_id_ex.rs_data;
  assign bus.id_ex_rt_data    = r_id_ex.rt_data;
  assign bus.id_ex_imm        = r_id_ex.imm;
  assign bus.id_ex_rs         = r_id_ex.rs;
  assign bus.id_ex_rt         = r_id_ex.rt;
  assign bus.id_ex_write_reg  = r_id_ex.ctrl.write_reg;
  assign bus.id_ex_reg_write  = r_id_ex.ctrl.reg_write;
  assign bus.id_ex_mem_read   = r_id_ex.ctrl.mem_read;
  assign bus.id_ex_mem_write  = r_id_ex.ctrl.mem_write;
  assign bus.id_ex_mem_to_reg = r_id_ex.ctrl.mem_to_reg;
  assign bus.id_ex_alu_src    = r_id_ex.ctrl.alu_src;
  assign bus.id_ex_link       = r_id_ex.ctrl.link;
  assign bus.id_ex_alu_op     = r_id_ex.ctrl.alu_op;

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the 5-stage pipelined MIPS core. It is the consumer of the IF/ID register produced by the fetch stage, and it returns that stage's control inputs: `stall`, `flush_if`, jump/branch requests and targets. It decodes the instruction, reads the register file, and resolves `beq`/`bne`/`j`/`jal` in ID. It detects load-use and branch-operand hazards and loads the ID/EX pipeline register.

## Interface
- No parameters. Data width is fixed at 32 bits; there are 32 registers.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `if_id_pc_next` in 32: PC+4 of the instruction in ID.
- `if_id_instruction` in 32: instruction in ID.
- `wb_reg_write` in 1, `wb_write_reg` in 5, `wb_write_data` in 32: writeback port.
- `ex_mem_reg_write` in 1, `ex_mem_mem_read` in 1, `ex_mem_write_reg` in 5, `ex_mem_alu_result` in 32: EX/MEM state, used for branch forwarding and hazards.
- `stall` out 1, `flush_if` out 1: to IF.
- `jump_taken` out 1, `pc_jump` out 32: jump request and target, to IF.
- `branch_eq_taken` out 1, `branch_neq_taken` out 1, `pc_branch` out 32: branch requests and target, to IF.
- ID/EX register outputs, all registered:
  - `id_ex_pc_next` 32
  - `id_ex_rs_data` 32, `id_ex_rt_data` 32
  - `id_ex_imm` 32
  - `id_ex_rs` 5, `id_ex_rt` 5, `id_ex_write_reg` 5
  - `id_ex_reg_write` 1, `id_ex_mem_read` 1, `id_ex_mem_write` 1, `id_ex_mem_to_reg` 1, `id_ex_alu_src` 1, `id_ex_link` 1
  - `id_ex_alu_op` 3

## Operation
- **Decoded instructions:**
  - R-type: add, sub, and, or, slt, nor.
  - I-type: addi, andi, ori, slti, lw, sw, beq, bne.
  - J-type: j, jal.
  - Any other opcode or funct decodes as a bubble (all control bits 0).
- **Immediate extension:** andi and ori zero-extend; all other instructions sign-extend.
- **Destination register (`id_ex_write_reg`):**
  - R-type writes rd.
  - I-type writes rt.
  - jal writes 31, with `id_ex_link`=1; EX then writes `id_ex_pc_next`.
- **Register file (`reg_file`):**
  - 32x32; r0 always reads 0.
  - Write occurs on a rising edge when `wb_reg_write` is 1 and `wb_write_reg` is non-zero.
  - Reads are combinational, with a WB bypass: a read of the register being written this cycle returns `wb_write_data`.
  - `rst` clears all registers.
- **Branch operand forwarding:** if `ex_mem_reg_write`=1, `ex_mem_mem_read`=0, and `ex_mem_write_reg` equals the source register (non-zero), the operand is `ex_mem_alu_result`. Otherwise it comes from the register file.
- **Hazards:** `stall` is the OR of the following. Register 0 never matches in any of them.
  - Load-use: `id_ex_mem_read`=1 and `id_ex_rt` matches rs, or matches rt when rt is a source (R-type, sw, beq, bne).
  - Branch after ALU op: beq/bne, with `id_ex_reg_write`=1 and `id_ex_write_reg` matching rs or rt.
  - Branch after load in MEM: beq/bne, with `ex_mem_mem_read`=1 and `ex_mem_write_reg` matching rs or rt.
- **Redirect:**
  - `pc_branch` = `if_id_pc_next` + (sign-extended imm << 2), computed modulo 2^32.
  - `pc_jump` = {`if_id_pc_next`[31:28], instr[25:0], 2'b00}.
  - `branch_eq_taken` = beq AND operands equal AND ~stall.
  - `branch_neq_taken` = bne AND operands unequal AND ~stall.
  - `jump_taken` = (j or jal) AND ~stall.
  - `flush_if` = OR of the three taken signals.
- **ID/EX load:**
  - When `stall`=1, a bubble is loaded: all control bits 0, data fields don't-care but driven 0.
  - Otherwise the decoded instruction is loaded. Taken branches and jumps also proceed.
- **Priority:** stall overrides any redirect.

## Timing
- `stall`, `flush_if`, the taken signals and both targets are combinational from the IF/ID inputs, the ID/EX state and the EX/MEM inputs, all in the same cycle.
- ID/EX has 1-cycle latency: the register is updated on the rising edge of `clk`.
- A load-use stall lasts exactly 1 cycle.
- A branch waiting on an ALU op in EX stalls for 1 cycle.
- A branch waiting on a load in EX stalls for 2 cycles: first the load-use condition, then the MEM-load condition.
- **Reset:** on `rst`, all ID/EX outputs and all registers go to 0 immediately (asynchronous). Combinational outputs follow from the cleared state. Reset mid-stall discards the pending instruction state in ID/EX.
- WB write and ID read of the same register in the same cycle: the read returns the new value.

## Structure
- Package `mips_pkg` holds:
  - opcode constants (R=0x00, j=0x02, jal=0x03, beq=0x04, bne=0x05, addi=0x08, slti=0x0A, andi=0x0C, ori=0x0D, lw=0x23, sw=0x2B);
  - funct constants (add=0x20, sub=0x22, and=0x24, or=0x25, nor=0x27, slt=0x2A);
  - the `alu_op` enum (ADD=0, SUB=1, AND=2, OR=3, SLT=4, NOR=5).
- Sub-module: `reg_file` (2 read ports, 1 write port, WB bypass).
- Decode, hazard detection and redirect logic live in `id_stage`.

## Test plan
- **Register file bypass:** WB writes r5=0x1234 while ID decodes `add r3,r5,r0` → `id_ex_rs_data`=0x1234 on the next edge.
- **Load-use:** `lw r2,0(r1)` in ID/EX and `add r4,r2,r3` in ID → `stall`=1 for 1 cycle and a bubble is loaded. The following cycle `stall`=0 and the add is loaded.
- **Branch taken with forwarding:**
  - Setup: `beq r1,r2,+3` at `if_id_pc_next`=0x104; EX/MEM holds an ALU write of r1=7; RF has r2=7.
  - Expected: `branch_eq_taken`=1, `pc_branch`=0x110, `flush_if`=1.
- **Branch waiting on a load in EX:** `lw r1` in EX, then `bne r1,r0` in ID → `stall`=1 for 2 cycles. No taken signal is asserted while stalled.
- **jal:** `jal 0x0000040` at `if_id_pc_next`=0x30000008.
  - Expected now: `pc_jump`=0x30000100, `jump_taken`=1.
  - Expected next cycle: `id_ex_write_reg`=31, `id_ex_link`=1, `id_ex_pc_next`=0x30000008.
- **Reset mid-operation:** assert `rst` asynchronously with valid ID/EX contents → all ID/EX outputs 0 before the next edge, and registers read 0 after reset.
